grab_trig_ctrl: RTL and testbench

- Parametrised grab-trigger front end for the XGS controller.
- Selects the grab source from IMMEDIATE, HW_TRIG, SW_TRIG or SFNC, and conditions the selected hardware input through a 2-flop synchronizer and a programmable glitch filter.
- Detects the configured activation (RISING, FALLING, ANY, LEVEL_HI, LEVEL_LO), applies a programmable trigger delay, and issues a grab request to the exposure sequencer over a req/ack handshake.
- Triggers that arrive while a grab is being launched are counted as missed.

---
 rtl/grab_trig_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_grab_trig_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/grab_trig_ctrl.sv
// rtl/grab_trig_ctrl.sv - grab-trigger front end: source select, sync, glitch filter, delay, req/ack
//
// Ports:
//   sys_clk, sys_reset          clock, synchronous active-high reset
//   cfg_*                       configuration, latched when the block is enabled
//   hw_trig_in                  asynchronous hardware trigger pins
//   sw_trig, sfnc_trig          single-cycle trigger pulses
//   grab_ack                    sequencer acknowledge for grab_req
//   missed_clr                  clears trig_missed_cnt
//   grab_req                    grab request, held until grab_ack
//   trig_event                  one-cycle pulse per accepted trigger
//   trig_armed                  high while waiting for a trigger
//   trig_missed_cnt             saturating count of triggers lost while busy
module grab_trig_ctrl #(
   parameter int NB_HW_TRIG = 4,
   parameter int FILT_W     = 8,
   parameter int DLY_W      = 16,
   parameter int CNT_W      = 16,
   localparam int SEL_W     = (NB_HW_TRIG > 1) ? $clog2(NB_HW_TRIG) : 1
) (
   input  logic                  sys_clk,
   input  logic                  sys_reset,
   input  logic                  cfg_enable,
   input  logic [2:0]            cfg_source,
   input  logic [2:0]            cfg_activation,
   input  logic [SEL_W-1:0]      cfg_hw_sel,
   input  logic [FILT_W-1:0]     cfg_filter,
   input  logic [DLY_W-1:0]      cfg_delay,
   input  logic [NB_HW_TRIG-1:0] hw_trig_in,
   input  logic                  sw_trig,
   input  logic                  sfnc_trig,
   input  logic                  grab_ack,
   input  logic                  missed_clr,
   output logic                  grab_req,
   output logic                  trig_event,
   output logic                  trig_armed,
   output logic [CNT_W-1:0]      trig_missed_cnt
);

   localparam logic [2:0] SRC_IMM  = 3'd1;
   localparam logic [2:0] SRC_HW   = 3'd2;
   localparam logic [2:0] SRC_SW   = 3'd3;
   localparam logic [2:0] SRC_SFNC = 3'd4;

   localparam logic [2:0] ACT_RISE = 3'd0;
   localparam logic [2:0] ACT_FALL = 3'd1;
   localparam logic [2:0] ACT_ANY  = 3'd2;
   localparam logic [2:0] ACT_LVLH = 3'd3;
   localparam logic [2:0] ACT_LVLL = 3'd4;

   typedef enum logic [1:0] {
      ST_DISABLED = 2'd0,
      ST_ARMED    = 2'd1,
      ST_DELAY    = 2'd2,
      ST_REQ      = 2'd3
   } state_t;

   state_t            state_q;
   logic [2:0]        src_q;
   logic [2:0]        act_q;
   logic [SEL_W-1:0]  sel_q;
   logic [FILT_W-1:0] filt_len_q;
   logic [DLY_W-1:0]  dly_q;
   logic [DLY_W-1:0]  dcnt_q;
   logic              grab_req_q;
   logic              armed_q;

   logic              sync1_q, sync2_q;
   logic              filt_q, filt_prev_q;
   logic [FILT_W-1:0] fcnt_q;
   logic [CNT_W-1:0]  miss_q;

   logic pin_sel, rise, fall;
   logic edge_evt, level_evt, any_evt, miss_inc;

   // Out-of-range selects (non power-of-two pin counts) read as a quiet pin.
   assign pin_sel = (int'(sel_q) < NB_HW_TRIG) ? hw_trig_in[sel_q] : 1'b0;

   // Synchronizer and glitch filter: filt_q only follows sync2_q after it has
   // disagreed for filt_len_q+1 consecutive cycles; any agreement restarts the count.
   always_ff @(posedge sys_clk) begin
      if (sys_reset) begin
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         filt_q      <= 1'b0;
         filt_prev_q <= 1'b0;
         fcnt_q      <= '0;
      end else begin
         sync1_q     <= pin_sel;
         sync2_q     <= sync1_q;
         filt_prev_q <= filt_q;
         if (sync2_q != filt_q) begin
            if (fcnt_q == filt_len_q) begin
               filt_q <= sync2_q;
               fcnt_q <= '0;
            end else begin
               fcnt_q <= fcnt_q + FILT_W'(1);
            end
         end else begin
            fcnt_q <= '0;
         end
      end
   end

   assign rise = filt_q & ~filt_prev_q;
   assign fall = ~filt_q & filt_prev_q;

   // Edge-type events can be missed; level and IMMEDIATE conditions are
   // continuous and are never counted as missed.
   always_comb begin
      edge_evt  = 1'b0;
      level_evt = 1'b0;
      case (src_q)
         SRC_IMM:  level_evt = 1'b1;
         SRC_HW: begin
            case (act_q)
               ACT_RISE: edge_evt  = rise;
               ACT_FALL: edge_evt  = fall;
               ACT_ANY:  edge_evt  = rise | fall;
               ACT_LVLH: level_evt = filt_q;
               ACT_LVLL: level_evt = ~filt_q;
               default:  ;
            endcase
         end
         SRC_SW:   edge_evt = sw_trig;
         SRC_SFNC: edge_evt = sfnc_trig;
         default:  ;
      endcase
   end

   assign any_evt    = edge_evt | level_evt;
   assign trig_event = (state_q == ST_ARMED) && cfg_enable && any_evt;
   assign miss_inc   = ((state_q == ST_DELAY) || (state_q == ST_REQ)) && edge_evt;

   always_ff @(posedge sys_clk) begin
      if (sys_reset) begin
         state_q    <= ST_DISABLED;
         src_q      <= '0;
         act_q      <= '0;
         sel_q      <= '0;
         filt_len_q <= '0;
         dly_q      <= '0;
         dcnt_q     <= '0;
         grab_req_q <= 1'b0;
         armed_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_DISABLED: begin
               if (cfg_enable) begin
                  src_q      <= cfg_source;
                  act_q      <= cfg_activation;
                  sel_q      <= cfg_hw_sel;
                  filt_len_q <= cfg_filter;
                  dly_q      <= cfg_delay;
                  state_q    <= ST_ARMED;
                  armed_q    <= 1'b1;
               end
            end
            ST_ARMED: begin
               if (!cfg_enable) begin
                  state_q <= ST_DISABLED;
                  armed_q <= 1'b0;
               end else if (any_evt) begin
                  armed_q <= 1'b0;
                  if (dly_q == '0) begin
                     state_q    <= ST_REQ;
                     grab_req_q <= 1'b1;
                  end else begin
                     state_q <= ST_DELAY;
                     dcnt_q  <= dly_q - DLY_W'(1);
                  end
               end
            end
            ST_DELAY: begin
               if (!cfg_enable) begin
                  state_q <= ST_DISABLED;
               end else if (dcnt_q == '0) begin
                  state_q    <= ST_REQ;
                  grab_req_q <= 1'b1;
               end else begin
                  dcnt_q <= dcnt_q - DLY_W'(1);
               end
            end
            ST_REQ: begin
               // The handshake always completes, even if disabled meanwhile.
               if (grab_ack) begin
                  grab_req_q <= 1'b0;
                  if (cfg_enable) begin
                     state_q <= ST_ARMED;
                     armed_q <= 1'b1;
                  end else begin
                     state_q <= ST_DISABLED;
                  end
               end
            end
            default: state_q <= ST_DISABLED;
         endcase
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_reset || missed_clr) begin
         miss_q <= '0;
      end else if (miss_inc && (miss_q != '1)) begin
         miss_q <= miss_q + CNT_W'(1);
      end
   end

   assign grab_req        = grab_req_q;
   assign trig_armed      = armed_q;
   assign trig_missed_cnt = miss_q;

endmodule

// File: tb/tb_grab_trig_ctrl.sv
// tb/tb_grab_trig_ctrl.sv - scoreboard bench for grab_trig_ctrl
module tb_grab_trig_ctrl;

   localparam logic [2:0] SRC_IMM  = 3'd1;
   localparam logic [2:0] SRC_HW   = 3'd2;
   localparam logic [2:0] SRC_SW   = 3'd3;
   localparam logic [2:0] ACT_RISE = 3'd0;
   localparam logic [2:0] ACT_FALL = 3'd1;
   localparam logic [2:0] ACT_LVLH = 3'd3;

   logic        sys_clk = 1'b0;
   logic        sys_reset = 1'b1;
   logic        cfg_enable = 1'b0;
   logic [2:0]  cfg_source = '0;
   logic [2:0]  cfg_activation = '0;
   logic [1:0]  cfg_hw_sel = '0;
   logic [7:0]  cfg_filter = '0;
   logic [15:0] cfg_delay = '0;
   logic [3:0]  hw_trig_in = '0;
   logic        sw_trig = 1'b0;
   logic        sfnc_trig = 1'b0;
   logic        grab_ack = 1'b0;
   logic        missed_clr = 1'b0;
   logic        grab_req;
   logic        trig_event;
   logic        trig_armed;
   logic [1:0]  trig_missed_cnt;

   int cyc = 0;
   int n_tests = 0;
   int n_fail = 0;
   int ev_q[$];
   int req_q[$];
   logic req_seen = 1'b0;
   int e0;

   grab_trig_ctrl #(
      .NB_HW_TRIG(4), .FILT_W(8), .DLY_W(16), .CNT_W(2)
   ) u_dut (
      .sys_clk(sys_clk), .sys_reset(sys_reset),
      .cfg_enable(cfg_enable), .cfg_source(cfg_source),
      .cfg_activation(cfg_activation), .cfg_hw_sel(cfg_hw_sel),
      .cfg_filter(cfg_filter), .cfg_delay(cfg_delay),
      .hw_trig_in(hw_trig_in), .sw_trig(sw_trig), .sfnc_trig(sfnc_trig),
      .grab_ack(grab_ack), .missed_clr(missed_clr),
      .grab_req(grab_req), .trig_event(trig_event),
      .trig_armed(trig_armed), .trig_missed_cnt(trig_missed_cnt)
   );

   always #5 sys_clk = ~sys_clk;
   always @(posedge sys_clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Values seen here are the ones sampled by edge cyc+1.
   always @(negedge sys_clk) begin
      if (!sys_reset) begin
         if (trig_event) begin
            if (ev_q.size() == 0) chk("unexpected_event_edge", cyc + 1, 0);
            else chk("event_edge", cyc + 1, ev_q.pop_front());
         end
         if (grab_req && !req_seen) begin
            if (req_q.size() == 0) chk("unexpected_req_edge", cyc + 1, 0);
            else chk("req_edge", cyc + 1, req_q.pop_front());
         end
      end
      req_seen = grab_req;
   end

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   // Returns when inputs driven next are sampled at edge e and outputs show
   // the values edge e samples.
   task automatic goto_edge(input int e);
      while (cyc < e - 1) tick();
   endtask

   task automatic sw_pulse();
      sw_trig = 1'b1;
      tick();
      sw_trig = 1'b0;
   endtask

   task automatic ack_pulse();
      grab_ack = 1'b1;
      tick();
      grab_ack = 1'b0;
   endtask

   task automatic enable_cfg(input logic [2:0] src, input logic [2:0] act,
                             input logic [1:0] sel, input logic [7:0] filt,
                             input logic [15:0] dly);
      cfg_source = src;
      cfg_activation = act;
      cfg_hw_sel = sel;
      cfg_filter = filt;
      cfg_delay = dly;
      cfg_enable = 1'b1;
      tick();
   endtask

   task automatic disable_blk();
      cfg_enable = 1'b0;
      tick();
      tick();
   endtask

   initial begin
      // reset
      repeat (3) tick();
      chk("rst_req", grab_req, 0);
      chk("rst_event", trig_event, 0);
      chk("rst_armed", trig_armed, 0);
      chk("rst_missed", trig_missed_cnt, 0);
      sys_reset = 1'b0;
      repeat (2) tick();
      chk("idle_armed", trig_armed, 0);

      // HW rising on pin 2, F=0 D=0
      enable_cfg(SRC_HW, ACT_RISE, 2'd2, 8'd0, 16'd0);
      chk("t1_armed", trig_armed, 1);
      repeat (3) tick();
      e0 = cyc + 1;
      ev_q.push_back(e0 + 3);
      req_q.push_back(e0 + 4);
      hw_trig_in[2] = 1'b1;
      goto_edge(e0 + 6);
      chk("t1_req_held", grab_req, 1);
      ack_pulse();
      chk("t1_req_drop", grab_req, 0);
      chk("t1_missed", trig_missed_cnt, 0);
      chk("t1_rearmed", trig_armed, 1);
      hw_trig_in = '0;
      repeat (6) tick();
      disable_blk();

      // Filter F=3, rising: short pulse dropped, 5-cycle pulse accepted
      enable_cfg(SRC_HW, ACT_RISE, 2'd1, 8'd3, 16'd0);
      repeat (2) tick();
      hw_trig_in[1] = 1'b1;
      repeat (3) tick();
      hw_trig_in[1] = 1'b0;
      repeat (10) tick();
      chk("t2_short_still_armed", trig_armed, 1);
      e0 = cyc + 1;
      ev_q.push_back(e0 + 6);
      req_q.push_back(e0 + 7);
      hw_trig_in[1] = 1'b1;
      repeat (5) tick();
      hw_trig_in[1] = 1'b0;
      goto_edge(e0 + 8);
      ack_pulse();
      repeat (8) tick();
      disable_blk();

      // Filter F=3, falling
      enable_cfg(SRC_HW, ACT_FALL, 2'd1, 8'd3, 16'd0);
      repeat (2) tick();
      hw_trig_in[1] = 1'b1;
      repeat (5) tick();
      e0 = cyc + 1;
      ev_q.push_back(e0 + 6);
      req_q.push_back(e0 + 7);
      hw_trig_in[1] = 1'b0;
      goto_edge(e0 + 8);
      ack_pulse();
      chk("t2_fall_req_drop", grab_req, 0);
      repeat (4) tick();
      disable_blk();

      // IMMEDIATE, D=0, ack held high: one request every 2 cycles
      grab_ack = 1'b1;
      e0 = cyc + 1;
      for (int k = 0; k < 3; k++) begin
         ev_q.push_back(e0 + 1 + 2 * k);
         req_q.push_back(e0 + 2 + 2 * k);
      end
      enable_cfg(SRC_IMM, 3'd0, 2'd0, 8'd0, 16'd0);
      chk("t_imm_armed", trig_armed, 1);
      goto_edge(e0 + 6);
      cfg_enable = 1'b0;
      tick();
      grab_ack = 1'b0;
      tick();
      chk("t_imm_req_off", grab_req, 0);
      chk("t_imm_disabled", trig_armed, 0);
      repeat (3) tick();

      // SW trigger, D=10, missed counting and clear priority
      enable_cfg(SRC_SW, 3'd0, 2'd0, 8'd0, 16'd10);
      tick();
      e0 = cyc + 1;
      ev_q.push_back(e0);
      req_q.push_back(e0 + 11);
      sw_pulse();
      goto_edge(e0 + 3);  sw_pulse();
      goto_edge(e0 + 13); sw_pulse();
      goto_edge(e0 + 15); sw_pulse();
      goto_edge(e0 + 17);
      chk("t3_missed3", trig_missed_cnt, 3);
      chk("t3_req_held", grab_req, 1);
      sw_trig = 1'b1;
      missed_clr = 1'b1;
      tick();
      sw_trig = 1'b0;
      missed_clr = 1'b0;
      chk("t3_clr_wins", trig_missed_cnt, 0);
      goto_edge(e0 + 20);
      ack_pulse();
      chk("t3_req_drop", grab_req, 0);
      chk("t3_rearmed", trig_armed, 1);

      // Saturation: 5 missed pulses with a 2-bit counter
      e0 = cyc + 1;
      ev_q.push_back(e0);
      req_q.push_back(e0 + 11);
      sw_pulse();
      for (int k = 1; k <= 5; k++) begin
         goto_edge(e0 + 2 * k);
         sw_pulse();
      end
      goto_edge(e0 + 12);
      chk("t4_saturated", trig_missed_cnt, 3);
      ack_pulse();
      missed_clr = 1'b1;
      tick();
      missed_clr = 1'b0;
      chk("t4_cleared", trig_missed_cnt, 0);
      disable_blk();

      // LEVEL_HI, ack one cycle after each request: period 3
      enable_cfg(SRC_HW, ACT_LVLH, 2'd0, 8'd0, 16'd0);
      tick();
      e0 = cyc + 1;
      for (int k = 0; k < 3; k++) begin
         ev_q.push_back(e0 + 3 + 3 * k);
         req_q.push_back(e0 + 4 + 3 * k);
      end
      hw_trig_in[0] = 1'b1;
      goto_edge(e0 + 5);  ack_pulse();
      goto_edge(e0 + 8);  ack_pulse();
      goto_edge(e0 + 9);  hw_trig_in[0] = 1'b0;
      goto_edge(e0 + 11); ack_pulse();
      repeat (8) tick();
      chk("t5_level_stopped", grab_req, 0);
      chk("t5_level_armed", trig_armed, 1);
      disable_blk();

      // Disable during DELAY aborts the request
      enable_cfg(SRC_SW, 3'd0, 2'd0, 8'd0, 16'd10);
      tick();
      e0 = cyc + 1;
      ev_q.push_back(e0);
      sw_pulse();
      goto_edge(e0 + 3);
      cfg_enable = 1'b0;
      tick();
      repeat (15) tick();
      chk("t6_no_req", grab_req, 0);
      chk("t6_not_armed", trig_armed, 0);

      // Disable during REQ: request held until ack, then DISABLED
      enable_cfg(SRC_SW, 3'd0, 2'd0, 8'd0, 16'd0);
      tick();
      e0 = cyc + 1;
      ev_q.push_back(e0);
      req_q.push_back(e0 + 1);
      sw_pulse();
      goto_edge(e0 + 2);
      cfg_enable = 1'b0;
      goto_edge(e0 + 4);
      chk("t7_req_kept", grab_req, 1);
      goto_edge(e0 + 5);
      ack_pulse();
      chk("t7_req_drop", grab_req, 0);
      chk("t7_disabled", trig_armed, 0);
      goto_edge(e0 + 8);
      sw_pulse();
      repeat (4) tick();

      // Reset while in REQ
      enable_cfg(SRC_SW, 3'd0, 2'd0, 8'd0, 16'd0);
      tick();
      e0 = cyc + 1;
      ev_q.push_back(e0);
      req_q.push_back(e0 + 1);
      sw_pulse();
      goto_edge(e0 + 3);
      chk("t8_req_before_rst", grab_req, 1);
      sys_reset = 1'b1;
      cfg_enable = 1'b0;
      tick();
      chk("t8_req_cleared", grab_req, 0);
      sys_reset = 1'b0;
      tick();
      chk("t8_armed_cleared", trig_armed, 0);
      repeat (4) tick();

      chk("event_queue_drained", ev_q.size(), 0);
      chk("req_queue_drained", req_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
